// File: rtl/lane_reorder_if.sv
// Lane reorder control/status bundle: ID capture inputs and reorder map outputs.
interface lane_reorder_if #(
  parameter int unsigned N_LANES = 20,
  parameter int unsigned NB_ID   = $clog2(N_LANES)
);

  logic                       i_reset_order;
  logic                       i_enable;
  logic                       i_valid;
  logic                       i_deskew_done;
  logic [N_LANES*NB_ID-1:0]   i_logical_rx_ID;
  logic [N_LANES*NB_ID-1:0]   o_reorder_mux_selector;
  logic                       o_update_selectors;
  logic                       o_locked;
  logic                       o_id_error;
  logic [N_LANES-1:0]         o_missing_lanes;
  logic                       o_fail;

  // Source of the receive-side controls and sink of the reorder map.
  modport master (
    output i_reset_order, i_enable, i_valid, i_deskew_done, i_logical_rx_ID,
    input  o_reorder_mux_selector, o_update_selectors, o_locked, o_id_error,
           o_missing_lanes, o_fail
  );

  // Reorder controller side.
  modport slave (
    input  i_reset_order, i_enable, i_valid, i_deskew_done, i_logical_rx_ID,
    output o_reorder_mux_selector, o_update_selectors, o_locked, o_id_error,
           o_missing_lanes, o_fail
  );

endinterface

// File: rtl/lane_reorder_fsm.sv
// Lane reorder controller: learns the logical-to-physical lane map one lane per
// qualifying cycle, validates it, and publishes it once the map is complete and clean.
module lane_reorder_fsm #(
  parameter int unsigned N_LANES   = 20,
  parameter int unsigned NB_ID     = $clog2(N_LANES),
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic         i_clock,
  input  logic         i_reset,
  lane_reorder_if.slave bus
);

  localparam int unsigned NB_CNT = $clog2(N_LANES + 1);
  localparam int unsigned NB_RTY = $clog2(MAX_RETRY + 1);
  localparam int unsigned NB_SEL = N_LANES * NB_ID;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CHECK,
    LOCKED,
    FAIL
  } state_t;

  // Identity map: field j (MSB field first) selects physical lane j.
  function automatic logic [NB_SEL-1:0] ident_map();
    logic [NB_SEL-1:0] v;
    v = '0;
    for (int j = 0; j < N_LANES; j++) begin
      v[(N_LANES-1-j)*NB_ID +: NB_ID] = NB_ID'(j);
    end
    return v;
  endfunction

  localparam logic [NB_SEL-1:0] IDENT = ident_map();

  state_t              state_q, state_n;
  logic [NB_CNT-1:0]   cnt_q, cnt_n;
  logic [NB_RTY-1:0]   rty_q, rty_n;
  logic [NB_ID-1:0]    map_q [N_LANES];
  logic [NB_ID-1:0]    map_n [N_LANES];
  logic [N_LANES-1:0]  pres_q, pres_n;
  logic                err_q, err_n;
  logic                err_last_q, err_last_n;
  logic [N_LANES-1:0]  miss_q, miss_n;
  logic                upd_n;
  logic                clr;

  logic [NB_ID-1:0]    cur_id;
  logic                id_ok;
  logic                qual;
  logic [NB_SEL-1:0]   map_sel;

  logic [NB_SEL-1:0]   sel_q;
  logic                upd_q;
  logic                locked_q;
  logic                id_err_q;
  logic                fail_q;

  assign qual  = bus.i_enable & bus.i_valid;
  assign id_ok = 32'(cur_id) < N_LANES;

  // Pick the received ID of the physical lane addressed by the collect counter.
  always_comb begin
    cur_id = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (cnt_q == NB_CNT'(k)) begin
        cur_id = bus.i_logical_rx_ID[(N_LANES-1-k)*NB_ID +: NB_ID];
      end
    end
  end

  // Pack the next map into selector layout (logical lane 0 in the MSB field).
  always_comb begin
    map_sel = '0;
    for (int k = 0; k < N_LANES; k++) begin
      map_sel[(N_LANES-1-k)*NB_ID +: NB_ID] = map_n[k];
    end
  end

  // Next-state and datapath update; restart and deskew loss override normal flow.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    rty_n      = rty_q;
    map_n      = map_q;
    pres_n     = pres_q;
    err_n      = err_q;
    err_last_n = err_last_q;
    miss_n     = miss_q;
    upd_n      = 1'b0;
    clr        = 1'b0;

    case (state_q)
      IDLE: begin
        clr   = 1'b1;
        rty_n = '0;
        if (bus.i_deskew_done) begin
          state_n = COLLECT;
        end
      end

      COLLECT: begin
        if (!bus.i_deskew_done) begin
          state_n = IDLE;
          clr     = 1'b1;
          rty_n   = '0;
        end else if (qual) begin
          cnt_n = cnt_q + NB_CNT'(1);
          if (id_ok) begin
            if (pres_q[cur_id]) begin
              err_n = 1'b1;
            end
            map_n[cur_id]  = NB_ID'(cnt_q);
            pres_n[cur_id] = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          if (cnt_q == NB_CNT'(N_LANES - 1)) begin
            state_n = CHECK;
          end
        end
      end

      CHECK: begin
        if (!bus.i_deskew_done) begin
          state_n = IDLE;
          clr     = 1'b1;
          rty_n   = '0;
        end else begin
          // Diagnostics of this pass stay visible until the next CHECK.
          err_last_n = err_q;
          miss_n     = ~pres_q;
          if (!err_q && (&pres_q)) begin
            state_n = LOCKED;
            upd_n   = 1'b1;
          end else begin
            rty_n = rty_q + NB_RTY'(1);
            if ((32'(rty_q) + 32'd1) >= MAX_RETRY) begin
              state_n = FAIL;
            end else begin
              state_n = COLLECT;
              cnt_n   = '0;
              map_n   = '{default: '0};
              pres_n  = '0;
              err_n   = 1'b0;
            end
          end
        end
      end

      LOCKED: begin
        if (!bus.i_deskew_done) begin
          state_n = IDLE;
          clr     = 1'b1;
          rty_n   = '0;
        end
      end

      FAIL: begin
        state_n = FAIL;
      end

      default: begin
        state_n = IDLE;
        clr     = 1'b1;
        rty_n   = '0;
      end
    endcase

    if (bus.i_reset_order) begin
      state_n = IDLE;
      clr     = 1'b1;
      rty_n   = '0;
      upd_n   = 1'b0;
    end

    if (clr) begin
      cnt_n      = '0;
      map_n      = '{default: '0};
      pres_n     = '0;
      err_n      = 1'b0;
      err_last_n = 1'b0;
      miss_n     = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rty_q      <= '0;
      map_q      <= '{default: '0};
      pres_q     <= '0;
      err_q      <= 1'b0;
      err_last_q <= 1'b0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      rty_q      <= rty_n;
      map_q      <= map_n;
      pres_q     <= pres_n;
      err_q      <= err_n;
      err_last_q <= err_last_n;
      miss_q     <= miss_n;
    end
  end

  // Registered outputs, derived from next state so they line up with the state register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sel_q    <= IDENT;
      upd_q    <= 1'b0;
      locked_q <= 1'b0;
      id_err_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      sel_q    <= (state_n == LOCKED) ? map_sel : IDENT;
      upd_q    <= upd_n;
      locked_q <= (state_n == LOCKED);
      id_err_q <= err_n | err_last_n;
      fail_q   <= (state_n == FAIL);
    end
  end

  assign bus.o_reorder_mux_selector = sel_q;
  assign bus.o_update_selectors     = upd_q;
  assign bus.o_locked               = locked_q;
  assign bus.o_id_error             = id_err_q;
  assign bus.o_missing_lanes        = miss_q;
  assign bus.o_fail                 = fail_q;

endmodule
